eee_imgproc_multi: RTL and testbench
====================================

// Module: eee_imgproc_multi
// PURPOSE
// Parametrised successor to the single-mode image processor in the VIP stream. It sits between
// the camera frame path and the frame buffer, on the Avalon-ST video link.
// It classifies every RGB pixel against N_CLASSES colour windows and tracks a bounding box per
// class. Boxes are latched at end of frame for the Nios over Avalon-MM. Optional mask and overlay
// output modes are provided.
// PARAMETERS
// N_CLASSES  4     number of colour classes (1..8)
// IMG_W      640   active pixels per line
// IMG_H      480   active lines per frame
// BPC        8     bits per colour component; data width is 3*BPC
// PORTS
// clk               in   1        system clock
// reset_n           in   1        asynchronous active-low reset
// sink_data         in   3*BPC    Avalon-ST video in, {R,G,B}
// sink_valid        in   1        input beat valid
// sink_sop          in   1        input start of packet
// sink_eop          in   1        input end of packet
// sink_ready        out  1        block accepts a beat
// source_data       out  3*BPC    video out
// source_valid      out  1        output beat valid
// source_sop        out  1        output start of packet
// source_eop        out  1        output end of packet
// source_ready      in   1        downstream accepts a beat
// mode              in   4        0=pass; k=1..N_CLASSES: mask of class k-1; other values=pass
// s_address         in   6        MM word address
// s_read            in   1        MM read
// s_write           in   1        MM write
// s_writedata       in   32       MM write data
// s_readdata        out  32       MM read data, valid 1 cycle after s_read
// irq               out  1        end-of-frame interrupt, level, cleared by write to STATUS
// BEHAVIOUR
// - Reset: all outputs 0; thresholds min=0, max=all-ones; boxes empty; frame counter 0.
//   The stream input discards beats until the next sop.
// - Stream: one output register stage, latency 1.
//   - sink_ready = source_ready | ~source_valid.
//   - A beat transfers on valid&ready; source holds data/sop/eop stable while valid&~ready.
// - Packet type: the beat with sop carries the type in data[3:0].
//   - Type 0 is video. Any other type is forwarded unmodified and gets no statistics.
// - Counters: x increments per video pixel and wraps from IMG_W-1 to 0 with y++.
//   - y saturates at IMG_H-1, so oversize frames are clipped.
//   - Both counters clear at sop.
// - Match i: every component satisfies min_i <= c <= max_i (unsigned, inclusive).
// - Box i (min_x, min_y, max_x, max_y) accumulates on each matching pixel.
//   - Empty accumulator = (IMG_W-1, IMG_H-1, 0, 0).
// - End of video frame (eop on a video packet, regardless of pixel count):
//   - latch all boxes and per-class pixel counts into the result registers;
//   - reset the accumulators;
//   - increment the frame counter and set irq.
//   - A later eop in the same cycle as an irq clear leaves irq set.
// - Threshold writes go to shadow registers. They are copied to the active registers at video
//   sop, so a frame never sees mixed thresholds.
// - mode is sampled at video sop.
//   - In mask mode, output is all-ones for a pixel matching class mode-1, else 0.
//   - sop/eop and non-video packets are unaffected by mode.
// - Register map (word addresses):
//   - 0 CTRL: bit0 enable. When 0, the block passes all data and freezes statistics.
//   - 1 STATUS: [15:0] frame count; irq flag clears on any write.
//   - 4+4i MIN {R,G,B}; 5+4i MAX {R,G,B};
//     6+4i BOX {min_y[31:16], min_x[15:0]}; 7+4i BOX {max_y, max_x}.
//   - A class with zero matches in the last frame reads min > max.
//   - Unmapped reads return 0.
// CONFIGURATION
// - BBOX_OVERLAY_EN defined:
//   - In mode 0, a video pixel lying on an edge of any class's latched (previous-frame)
//     non-empty box is replaced by {all-ones,0,0} (red).
//   - Latency is unchanged.
// - Undefined: no overlay logic; mode 0 is pure pass-through.
// TESTING
// - Reset asserted mid-frame, then released, then beats without sop -> no output beats.
//   Output resumes at the next sop.
// - 8x4 frame (IMG_W=8, IMG_H=4), class0 window R 200..255, G/B 0..50;
//   red pixels at (2,1) and (5,3) -> BOX0 = (2,1)/(5,3), irq=1, frame count=1.
// - source_ready toggled 1/0 every cycle over a 32-pixel frame -> output identical to input,
//   no beat lost or duplicated, sop/eop aligned.
// - mode=1 with the same frame -> exactly 2 all-ones pixels, all others 0x000000.
// - Control packet (type 0xF, 3 beats) -> forwarded unchanged; frame count and boxes unchanged.
// - MAX0 written mid-frame -> current frame's result uses the old window; next frame uses the new.

Source files
------------

// File: rtl/eee_imgproc_multi.sv
// Avalon-ST RGB classifier: N colour windows, per-class bounding boxes, Avalon-MM results.
// Optional macro BBOX_OVERLAY_EN draws previous-frame boxes in red when mode is 0.
module eee_imgproc_multi #(
  parameter int N_CLASSES = 4,
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int BPC       = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3*BPC-1:0]     sink_data,
  input  logic                 sink_valid,
  input  logic                 sink_sop,
  input  logic                 sink_eop,
  output logic                 sink_ready,
  output logic [3*BPC-1:0]     source_data,
  output logic                 source_valid,
  output logic                 source_sop,
  output logic                 source_eop,
  input  logic                 source_ready,
  input  logic [3:0]           mode,
  input  logic [5:0]           s_address,
  input  logic                 s_read,
  input  logic                 s_write,
  input  logic [31:0]          s_writedata,
  output logic [31:0]          s_readdata,
  output logic                 irq
);
  localparam int DW = 3*BPC;
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW = $clog2(IMG_W*IMG_H + 1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  function automatic logic in_window(input logic [DW-1:0] px, input logic [DW-1:0] lo,
                                     input logic [DW-1:0] hi);
    logic ok;
    ok = 1'b1;
    for (int c = 0; c < 3; c++)
      ok = ok & (px[c*BPC +: BPC] >= lo[c*BPC +: BPC]) & (px[c*BPC +: BPC] <= hi[c*BPC +: BPC]);
    return ok;
  endfunction

  logic [DW-1:0] min_sh [N_CLASSES];
  logic [DW-1:0] max_sh [N_CLASSES];
  logic [DW-1:0] min_act [N_CLASSES];
  logic [DW-1:0] max_act [N_CLASSES];
  logic [XW-1:0] acc_x0 [N_CLASSES], acc_x1 [N_CLASSES], nx_x0 [N_CLASSES], nx_x1 [N_CLASSES];
  logic [YW-1:0] acc_y0 [N_CLASSES], acc_y1 [N_CLASSES], nx_y0 [N_CLASSES], nx_y1 [N_CLASSES];
  logic [XW-1:0] res_x0 [N_CLASSES], res_x1 [N_CLASSES];
  logic [YW-1:0] res_y0 [N_CLASSES], res_y1 [N_CLASSES];
  logic [CW-1:0] acc_cnt [N_CLASSES], nx_cnt [N_CLASSES], res_cnt [N_CLASSES];
  logic [N_CLASSES-1:0] match, mask_sel, sel_mode;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [15:0]   frame_cnt;
  logic [DW-1:0] out_px;
  logic [31:0]   rd_val;
  logic enable, in_pkt, is_video;
  logic accept, fwd, pixel, video_sop, frame_end;

  assign sink_ready = source_ready | ~source_valid;
  assign accept     = sink_valid & sink_ready;
  assign fwd        = accept & (sink_sop | in_pkt);
  assign pixel      = accept & in_pkt & ~sink_sop & is_video;
  assign video_sop  = accept & sink_sop & (sink_data[3:0] == 4'd0);
  assign frame_end  = accept & sink_eop & (sink_sop ? video_sop : (in_pkt & is_video));

  // Window match, mode decode and accumulators updated with the beat being accepted.
  always_comb begin
    match    = '0;
    sel_mode = '0;
    for (int i = 0; i < N_CLASSES; i++) begin
      match[i]    = in_window(sink_data, min_act[i], max_act[i]);
      sel_mode[i] = (mode == 4'(i + 1));
      nx_x0[i]  = (pixel && enable && match[i] && x < acc_x0[i]) ? x : acc_x0[i];
      nx_x1[i]  = (pixel && enable && match[i] && x > acc_x1[i]) ? x : acc_x1[i];
      nx_y0[i]  = (pixel && enable && match[i] && y < acc_y0[i]) ? y : acc_y0[i];
      nx_y1[i]  = (pixel && enable && match[i] && y > acc_y1[i]) ? y : acc_y1[i];
      nx_cnt[i] = (pixel && enable && match[i] && acc_cnt[i] != {CW{1'b1}})
                  ? acc_cnt[i] + CW'(1) : acc_cnt[i];
    end
  end

`ifdef BBOX_OVERLAY_EN
  logic on_edge, mode_zero;

  // Current pixel lies on an edge of a non-empty latched box.
  always_comb begin
    on_edge = 1'b0;
    for (int i = 0; i < N_CLASSES; i++)
      on_edge = on_edge | ((res_cnt[i] != '0) &&
        (((x == res_x0[i] || x == res_x1[i]) && y >= res_y0[i] && y <= res_y1[i]) ||
         ((y == res_y0[i] || y == res_y1[i]) && x >= res_x0[i] && x <= res_x1[i])));
  end
`endif

  // Output pixel selection: mask, optional overlay, or pass-through.
  always_comb begin
    out_px = sink_data;
    if (pixel && enable && (|mask_sel))
      out_px = (|(match & mask_sel)) ? {DW{1'b1}} : {DW{1'b0}};
`ifdef BBOX_OVERLAY_EN
    else if (pixel && enable && mode_zero && on_edge)
      out_px = {{BPC{1'b1}}, {(2*BPC){1'b0}}};
`endif
    else
      out_px = sink_data;
  end

  // Output register stage plus packet tracking and pixel coordinates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      source_valid <= 1'b0;
      source_data  <= '0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      in_pkt       <= 1'b0;
      is_video     <= 1'b0;
      x            <= '0;
      y            <= '0;
    end else begin
      if (fwd) begin
        source_valid <= 1'b1;
        source_data  <= out_px;
        source_sop   <= sink_sop;
        source_eop   <= sink_eop;
      end else if (source_ready) begin
        source_valid <= 1'b0;
      end
      if (accept && sink_sop) begin
        in_pkt   <= ~sink_eop;
        is_video <= (sink_data[3:0] == 4'd0);
        x        <= '0;
        y        <= '0;
      end else if (accept && in_pkt) begin
        in_pkt <= ~sink_eop;
        if (is_video && x == X_LAST) begin
          x <= '0;
          y <= (y == Y_LAST) ? y : y + YW'(1);
        end else if (is_video) begin
          x <= x + XW'(1);
        end
      end
    end
  end

  // Active thresholds and mode captured at video sop; box accumulation and end-of-frame latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CLASSES; i++) begin
        min_act[i] <= '0;          max_act[i] <= '1;
        acc_x0[i]  <= X_LAST;      acc_y0[i]  <= Y_LAST;
        acc_x1[i]  <= '0;          acc_y1[i]  <= '0;      acc_cnt[i] <= '0;
        res_x0[i]  <= X_LAST;      res_y0[i]  <= Y_LAST;
        res_x1[i]  <= '0;          res_y1[i]  <= '0;      res_cnt[i] <= '0;
      end
      mask_sel  <= '0;
      frame_cnt <= 16'd0;
      irq       <= 1'b0;
`ifdef BBOX_OVERLAY_EN
      mode_zero <= 1'b0;
`endif
    end else begin
      if (video_sop) begin
        for (int i = 0; i < N_CLASSES; i++) begin
          min_act[i] <= min_sh[i];
          max_act[i] <= max_sh[i];
        end
        mask_sel <= sel_mode;
`ifdef BBOX_OVERLAY_EN
        mode_zero <= (mode == 4'd0);
`endif
      end
      for (int i = 0; i < N_CLASSES; i++) begin
        if (frame_end && enable) begin
          res_x0[i] <= nx_x0[i];  res_x1[i] <= nx_x1[i];
          res_y0[i] <= nx_y0[i];  res_y1[i] <= nx_y1[i];  res_cnt[i] <= nx_cnt[i];
          acc_x0[i] <= X_LAST;    acc_y0[i] <= Y_LAST;
          acc_x1[i] <= '0;        acc_y1[i] <= '0;        acc_cnt[i] <= '0;
        end else begin
          acc_x0[i] <= nx_x0[i];  acc_x1[i] <= nx_x1[i];
          acc_y0[i] <= nx_y0[i];  acc_y1[i] <= nx_y1[i];  acc_cnt[i] <= nx_cnt[i];
        end
      end
      if (frame_end && enable) frame_cnt <= frame_cnt + 16'd1;
      if (frame_end && enable) irq <= 1'b1;
      else if (s_write && s_address == 6'd1) irq <= 1'b0;
      else irq <= irq;
    end
  end

  // Register read decode; a class with no matches reads as an inverted (empty) box.
  always_comb begin
    rd_val = 32'd0;
    case (s_address)
      6'd0:    rd_val = {31'd0, enable};
      6'd1:    rd_val = {16'd0, frame_cnt};
      default: begin
        for (int i = 0; i < N_CLASSES; i++) begin
          if (s_address == 6'(4 + 4*i))      rd_val = 32'(min_sh[i]);
          else if (s_address == 6'(5 + 4*i)) rd_val = 32'(max_sh[i]);
          else if (s_address == 6'(6 + 4*i))
            rd_val = (res_cnt[i] == '0) ? {16'(Y_LAST), 16'(X_LAST)}
                                        : {16'(res_y0[i]), 16'(res_x0[i])};
          else if (s_address == 6'(7 + 4*i))
            rd_val = (res_cnt[i] == '0) ? 32'd0 : {16'(res_y1[i]), 16'(res_x1[i])};
          else rd_val = rd_val;
        end
      end
    endcase
  end

  // Avalon-MM control and shadow threshold registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable     <= 1'b1;
      s_readdata <= 32'd0;
      for (int i = 0; i < N_CLASSES; i++) begin
        min_sh[i] <= '0;
        max_sh[i] <= '1;
      end
    end else begin
      s_readdata <= s_read ? rd_val : 32'd0;
      if (s_write && s_address == 6'd0) enable <= s_writedata[0];
      for (int i = 0; i < N_CLASSES; i++) begin
        if (s_write && s_address == 6'(4 + 4*i)) min_sh[i] <= s_writedata[DW-1:0];
        if (s_write && s_address == 6'(5 + 4*i)) max_sh[i] <= s_writedata[DW-1:0];
      end
    end
  end

  generate
    if (DW < 32) begin : g_wdata_pad
      logic unused_wdata;
      assign unused_wdata = ^s_writedata[31:DW];
    end
  endgenerate
endmodule

// File: tb/tb_eee_imgproc_multi.sv
// Bench for eee_imgproc_multi on an 8x4 image: directed steps plus random frames
// checked against a frame-level reference model.
module tb_eee_imgproc_multi;
  localparam int NC = 4, W = 8, H = 4, BPC = 8, DW = 24;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [DW-1:0] sink_data = '0, source_data;
  logic sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0, sink_ready;
  logic source_valid, source_sop, source_eop, source_ready = 1'b1;
  logic [3:0] mode = 4'd0;
  logic [5:0] s_address = 6'd0;
  logic s_read = 1'b0, s_write = 1'b0, irq;
  logic [31:0] s_writedata = 32'd0, s_readdata;

  eee_imgproc_multi #(.N_CLASSES(NC), .IMG_W(W), .IMG_H(H), .BPC(BPC)) dut (
    .clk(clk), .reset_n(reset_n),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_ready(sink_ready),
    .source_data(source_data), .source_valid(source_valid), .source_sop(source_sop),
    .source_eop(source_eop), .source_ready(source_ready),
    .mode(mode), .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata), .irq(irq));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic rdy_toggle = 1'b0;

  // Downstream backpressure, changed just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    source_ready = rdy_toggle ? ~source_ready : 1'b1;
  end

  logic [DW+1:0] got_q[$];
  logic [DW+1:0] exp_q[$];

  always @(negedge clk)
    if (reset_n && source_valid && source_ready) got_q.push_back({source_sop, source_eop, source_data});

  // Reference model state.
  logic [DW-1:0] sh_min [NC];
  logic [DW-1:0] sh_max [NC];
  logic [31:0] m_box0 [NC];
  logic [31:0] m_box1 [NC];
  logic [DW-1:0] frame [W*H];
  int fcount;
  logic m_irq, m_en;

  function automatic logic in_win(input logic [DW-1:0] p, input logic [DW-1:0] lo,
                                  input logic [DW-1:0] hi);
    for (int c = 0; c < 3; c++)
      if (p[c*8 +: 8] < lo[c*8 +: 8] || p[c*8 +: 8] > hi[c*8 +: 8]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      sh_min[k] = '0; sh_max[k] = '1;
      m_box0[k] = {16'(H-1), 16'(W-1)}; m_box1[k] = 32'd0;
    end
    fcount = 0; m_irq = 1'b0; m_en = 1'b1;
  endtask

  task automatic mm_write(input logic [5:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_write = 1'b1;
    @(negedge clk);
    s_write = 1'b0;
    if (a == 6'd0) m_en = d[0];
    if (a == 6'd1) m_irq = 1'b0;
    for (int k = 0; k < NC; k++) begin
      if (a == 6'(4 + 4*k)) sh_min[k] = d[DW-1:0];
      if (a == 6'(5 + 4*k)) sh_max[k] = d[DW-1:0];
    end
  endtask

  task automatic mm_read(input logic [5:0] a, output logic [31:0] d);
    s_address = a; s_read = 1'b1;
    @(negedge clk);
    s_read = 1'b0;
    d = s_readdata;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic s, input logic e);
    int n;
    sink_valid = 1'b1; sink_data = d; sink_sop = s; sink_eop = e;
    n = 0;
    while (!sink_ready && n < 50) begin @(negedge clk); n++; end
    if (!sink_ready) check("sink_ready_timeout", {31'd0, sink_ready}, 32'd1);
    @(negedge clk);
    sink_valid = 1'b0;
  endtask

  task automatic send_video(input int mode_v, input int wr_at, input logic [5:0] wa,
                            input logic [31:0] wd);
    logic [DW-1:0] amin [NC];
    logic [DW-1:0] amax [NC];
    logic [DW-1:0] o;
    int mx0, my0, mx1, my1, px, py;
    for (int k = 0; k < NC; k++) begin amin[k] = sh_min[k]; amax[k] = sh_max[k]; end
    mode = 4'(mode_v);
    exp_q.push_back({2'b10, 24'h000000});
    send_beat(24'h000000, 1'b1, 1'b0);
    for (int j = 0; j < W*H; j++) begin
      if (j == wr_at) mm_write(wa, wd);
      o = frame[j];
      if (m_en && mode_v >= 1 && mode_v <= NC)
        o = in_win(frame[j], amin[mode_v-1], amax[mode_v-1]) ? 24'hFFFFFF : 24'h000000;
      exp_q.push_back({1'b0, (j == W*H-1), o});
      send_beat(frame[j], 1'b0, j == W*H-1);
    end
    if (m_en) begin
      for (int k = 0; k < NC; k++) begin
        mx0 = W-1; my0 = H-1; mx1 = 0; my1 = 0;
        for (int j = 0; j < W*H; j++) begin
          px = j % W;
          py = (j / W < H) ? j / W : H-1;
          if (in_win(frame[j], amin[k], amax[k])) begin
            if (px < mx0) mx0 = px;
            if (px > mx1) mx1 = px;
            if (py < my0) my0 = py;
            if (py > my1) my1 = py;
          end
        end
        m_box0[k] = {16'(my0), 16'(mx0)};
        m_box1[k] = {16'(my1), 16'(mx1)};
      end
      fcount++;
      m_irq = 1'b1;
    end
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_nbeats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_beat"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_results(input string tag);
    logic [31:0] d;
    mm_read(6'd1, d);
    check({tag, "_status"}, d, {16'd0, 16'(fcount)});
    for (int k = 0; k < NC; k++) begin
      mm_read(6'(6 + 4*k), d);
      check({tag, "_boxmin"}, d, m_box0[k]);
      mm_read(6'(7 + 4*k), d);
      check({tag, "_boxmax"}, d, m_box1[k]);
    end
    check({tag, "_irq"}, {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic directed_frame(input logic [7:0] red);
    for (int j = 0; j < W*H; j++)
      frame[j] = {8'($urandom_range(0, 199)), 8'($urandom), 8'($urandom)};
    frame[1*W + 2] = {red, 8'd10, 8'd20};
    frame[3*W + 5] = {red, 8'd0, 8'd50};
  endtask

  task automatic rand_frame();
    for (int j = 0; j < W*H; j++)
      if ($urandom_range(0, 3) == 0)
        frame[j] = {8'($urandom_range(200, 255)), 8'($urandom_range(0, 50)), 8'($urandom_range(0, 50))};
      else
        frame[j] = 24'($urandom);
  endtask

  task automatic rand_window(input int k);
    logic [23:0] lo, hi;
    int l;
    for (int c = 0; c < 3; c++) begin
      l = $urandom_range(0, 180);
      lo[c*8 +: 8] = 8'(l);
      hi[c*8 +: 8] = 8'($urandom_range(l, 255));
    end
    mm_write(6'(4 + 4*k), {8'd0, lo});
    mm_write(6'(5 + 4*k), {8'd0, hi});
  endtask

  initial begin
    logic [31:0] d, d2;
    int n1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_src_valid", {31'd0, source_valid}, 32'd0);
    check("rst_src_sopeop", {30'd0, source_sop, source_eop}, 32'd0);
    check("rst_src_data", 32'(source_data), 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_readdata", s_readdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_results("rst");
    mm_read(6'd4, d);  check("rst_min0", d, 32'h00000000);
    mm_read(6'd5, d);  check("rst_max0", d, 32'h00FFFFFF);
    mm_read(6'd2, d);  check("unmapped2", d, 32'd0);
    mm_read(6'd63, d); check("unmapped63", d, 32'd0);

    mm_write(6'd0, 32'd1);
    mm_read(6'd0, d);  check("ctrl", d, 32'd1);
    mm_write(6'd4, {8'd0, 8'd200, 8'd0, 8'd0});
    mm_write(6'd5, {8'd0, 8'd255, 8'd50, 8'd50});
    rand_window(1);

    // Directed frame with two red pixels.
    directed_frame(8'd240);
    send_video(0, -1, 6'd0, 32'd0);
    drain();
    check_stream("frame1");
    check_results("frame1");
    mm_read(6'd6, d); check("box0_min_literal", d, 32'h00010002);
    mm_read(6'd7, d); check("box0_max_literal", d, 32'h00030005);
    mm_read(6'd1, d); check("fcount_literal", d, 32'd1);
    check("irq_literal", {31'd0, irq}, 32'd1);
    mm_write(6'd1, 32'd0);
    check("irq_clear", {31'd0, irq}, 32'd0);

    // Mask mode on the same frame.
    send_video(1, -1, 6'd0, 32'd0);
    drain();
    n1 = 0;
    foreach (got_q[i]) if (got_q[i][DW-1:0] == 24'hFFFFFF) n1++;
    check("mask_ones", n1, 2);
    check_stream("mask1");
    check_results("mask1");

    // Backpressure toggling every cycle.
    rdy_toggle = 1'b1;
    rand_frame();
    send_video(0, -1, 6'd0, 32'd0);
    drain();
    check_stream("toggle");
    check_results("toggle");
    rdy_toggle = 1'b0;

    // Control packet passes untouched, statistics unchanged.
    for (int b = 0; b < 3; b++) begin
      d = (b == 0) ? 32'h0000000F : $urandom;
      exp_q.push_back({(b == 0), (b == 2), d[DW-1:0]});
      send_beat(d[DW-1:0], b == 0, b == 2);
    end
    drain();
    check_stream("ctrlpkt");
    check_results("ctrlpkt");

    // MAX0 rewritten mid-frame: new window only applies from the next frame.
    directed_frame(8'd240);
    send_video(0, 12, 6'd5, {8'd0, 8'd220, 8'd50, 8'd50});
    drain();
    check_stream("midwr_a");
    check_results("midwr_a");
    send_video(0, -1, 6'd0, 32'd0);
    drain();
    check_stream("midwr_b");
    check_results("midwr_b");
    mm_read(6'd6, d); mm_read(6'd7, d2);
    check("empty_min_gt_max", {31'd0, d[15:0] > d2[15:0]}, 32'd1);

    // Disabled: pure pass-through even in mask mode, statistics frozen.
    mm_write(6'd0, 32'd0);
    rand_frame();
    send_video(2, -1, 6'd0, 32'd0);
    drain();
    check_stream("disabled");
    check_results("disabled");
    mm_write(6'd0, 32'd1);

    // Random frames, modes and windows.
    for (int r = 0; r < 4; r++) begin
      rand_window($urandom_range(1, NC-1));
      rand_frame();
      send_video($urandom_range(0, 6), -1, 6'd0, 32'd0);
      drain();
      check_stream("rand");
      check_results("rand");
    end

    // Reset in mid-frame, then beats without sop must be dropped.
    rand_frame();
    send_beat(24'h000000, 1'b1, 1'b0);
    for (int j = 0; j < 10; j++) send_beat(frame[j], 1'b0, 1'b0);
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    got_q.delete();
    exp_q.delete();
    for (int j = 0; j < 5; j++) send_beat(frame[j], 1'b0, j == 4);
    drain();
    check("post_reset_no_output", got_q.size(), 0);
    got_q.delete();
    mm_write(6'd0, 32'd1);
    send_video(0, -1, 6'd0, 32'd0);
    drain();
    check_stream("resume");
    check_results("resume");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
